taillight_input_ctrl: RTL and testbench

Front-end stage for the Thunderbird tail-light sequencer. Takes the board clock and raw, bouncy LEFT/RIGHT/HAZ switches, and divides the board clock down to the slow sequencing clock Clk_2Hz. Synchronizes and debounces each switch, then publishes clean LEFT/RIGHT/HAZ levels. Those levels change only in the low phase of Clk_2Hz, so they are stable at every Clk_2Hz rising edge seen by the downstream light sequencer.

---
 rtl/taillight_input_ctrl.sv | 120 ++++++++++++
 tb/tb_taillight_input_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taillight_input_ctrl.sv
// Tail-light front end: 2 Hz divider, switch sync/debounce, publish on Clk_2Hz fall.
// Define HAZ_TOGGLE_EN to treat SW_HAZ as a push-button toggling a hazard latch.
module taillight_input_ctrl #(
  parameter int HALF_PERIOD = 12_500_000,
  parameter int DB_CYCLES   = 500_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic SW_LEFT,
  input  logic SW_RIGHT,
  input  logic SW_HAZ,
  output logic Clk_2Hz,
  output logic LEFT,
  output logic RIGHT,
  output logic HAZ
);

  localparam int DW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);

  logic [DW-1:0] div_cnt;
  logic          div_wrap;
  logic          fall;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign fall     = div_wrap & Clk_2Hz;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt <= '0;
      Clk_2Hz <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      Clk_2Hz <= ~Clk_2Hz;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Bit order: [0]=left, [1]=right, [2]=hazard
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    db;
  logic [2:0]    accept;
  logic [CW-1:0] db_cnt [3];

  assign raw = {SW_HAZ, SW_RIGHT, SW_LEFT};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < 3; i++) begin
      accept[i] = (sync2[i] != db[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      db <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  logic haz_src;

`ifdef HAZ_TOGGLE_EN
  logic haz_latch;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      haz_latch <= 1'b0;
    end else if (accept[2] && sync2[2]) begin
      haz_latch <= ~haz_latch;
    end
  end

  assign haz_src = haz_latch;
`else
  assign haz_src = db[2];
`endif

  // Outputs move only on the falling divider edge so downstream rising edges see stable levels
  always_ff @(posedge Clk) begin
    if (Reset) begin
      LEFT  <= 1'b0;
      RIGHT <= 1'b0;
      HAZ   <= 1'b0;
    end else if (fall) begin
      LEFT  <= db[0];
      RIGHT <= db[1];
      HAZ   <= haz_src;
    end
  end

endmodule

// File: tb/tb_taillight_input_ctrl.sv
// Self-checking bench for taillight_input_ctrl (HALF_PERIOD=4, DB_CYCLES=3).
// Honours HAZ_TOGGLE_EN when the same define is given to the bench.
module tb_taillight_input_ctrl;

  localparam int HP  = 4;
  localparam int DB  = 3;
  localparam int PER = 2 * HP;

  logic Clk      = 1'b0;
  logic Reset    = 1'b1;
  logic SW_LEFT  = 1'b0;
  logic SW_RIGHT = 1'b0;
  logic SW_HAZ   = 1'b0;
  logic Clk_2Hz;
  logic LEFT;
  logic RIGHT;
  logic HAZ;

  int tests = 0;
  int fails = 0;

  // Reference model state: edges since reset, stable levels, mismatch runs
  int n = 0;
  bit m_lvl [3];
  int m_run [3];
  bit m_p1  [3];
  bit m_p2  [3];
  bit m_pub [3];
  bit m_latch;
  bit m_clk;

  taillight_input_ctrl #(
    .HALF_PERIOD(HP),
    .DB_CYCLES(DB)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .SW_LEFT(SW_LEFT),
    .SW_RIGHT(SW_RIGHT),
    .SW_HAZ(SW_HAZ),
    .Clk_2Hz(Clk_2Hz),
    .LEFT(LEFT),
    .RIGHT(RIGHT),
    .HAZ(HAZ)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    bit raw [3];
    bit pre [3];
    bit pre_latch;
    bit rst;
    raw[0] = SW_LEFT;
    raw[1] = SW_RIGHT;
    raw[2] = SW_HAZ;
    rst = Reset;
    @(posedge Clk);
    if (rst) begin
      n = 0;
      m_latch = 0;
      for (int i = 0; i < 3; i++) begin
        m_lvl[i] = 0; m_run[i] = 0;
        m_p1[i] = 0; m_p2[i] = 0; m_pub[i] = 0;
      end
    end else begin
      n++;
      pre = m_lvl;
      pre_latch = m_latch;
      for (int i = 0; i < 3; i++) begin
        if (m_p2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_lvl[i] = m_p2[i];
            m_run[i] = 0;
            if (i == 2 && m_lvl[2]) m_latch = !m_latch;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_p2 = m_p1;
      m_p1 = raw;
      if (n % PER == 0) begin
        m_pub[0] = pre[0];
        m_pub[1] = pre[1];
`ifdef HAZ_TOGGLE_EN
        m_pub[2] = pre_latch;
`else
        m_pub[2] = pre[2];
`endif
      end
    end
    m_clk = ((n / HP) % 2) == 1;
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    int highs;
    logic exp_clk;
    SW_LEFT = 0; SW_RIGHT = 0; SW_HAZ = 0;
    Reset = 1'b1;
    repeat (5) begin
      tick();
      tests++;
      if ({Clk_2Hz, LEFT, RIGHT, HAZ} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_hold: got %b expected 0000", {Clk_2Hz, LEFT, RIGHT, HAZ});
      end
    end
    Reset = 1'b0;
    highs = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_clk = (k >= 4 && k < 8) || (k >= 12 && k < 16);
      if (k > 8) highs += int'(Clk_2Hz);
      tests++;
      if ({Clk_2Hz, LEFT, RIGHT, HAZ} !== {exp_clk, 3'b000}) begin
        fails++;
        $display("FAIL divider_edge%0d: got %b expected %b", k,
                 {Clk_2Hz, LEFT, RIGHT, HAZ}, {exp_clk, 3'b000});
      end
    end
    tests++;
    if (highs != HP) begin
      fails++;
      $display("FAIL duty: got %0d high cycles expected %0d", highs, HP);
    end
  endtask

  task automatic test_left_step();
    logic [2:0] exp;
    SW_LEFT = 0; SW_RIGHT = 0; SW_HAZ = 0;
    do_reset();
    SW_LEFT = 1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp = {(k >= 8), 2'b00};
      tests++;
      if ({LEFT, RIGHT, HAZ} !== exp) begin
        fails++;
        $display("FAIL left_step_edge%0d: got %b expected %b", k, {LEFT, RIGHT, HAZ}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    int s;
    int exp_f;
    bit done;
    SW_LEFT = 0; SW_RIGHT = 0; SW_HAZ = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      SW_RIGHT = ((i % 4) < 2);
      tick();
      tests++;
      if (RIGHT !== 1'b0) begin
        fails++;
        $display("FAIL glitch_right_%0d: got %b expected 0", i, RIGHT);
      end
    end
    s = n;
    exp_f = ((s + 6 + PER - 1) / PER) * PER;
    SW_RIGHT = 1;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (RIGHT === 1'b1) done = 1;
    end
    tests++;
    if (!done || n != exp_f) begin
      fails++;
      $display("FAIL right_hold: rose at edge %0d (seen=%0d) expected edge %0d", n, done, exp_f);
    end
  endtask

  task automatic test_phase();
    logic pc;
    logic pl;
    bit pending;
    int changes;
    SW_LEFT = 0; SW_RIGHT = 0; SW_HAZ = 0;
    do_reset();
    pending = 0;
    changes = 0;
    for (int i = 0; i < 96; i++) begin
      pc = Clk_2Hz;
      pl = LEFT;
      tick();
      if (pending) begin
        SW_LEFT = ~SW_LEFT;
        pending = 0;
      end
      if (!pc && Clk_2Hz) begin
        tests++;
        if (LEFT !== pl) begin
          fails++;
          $display("FAIL left_at_rise edge %0d: got %b expected %b", n, LEFT, pl);
        end
        if (($urandom % 2) == 1 || changes == 0) begin
          pending = 1;
          changes++;
        end
      end
      tests++;
      if ({Clk_2Hz, LEFT} !== {m_clk, m_pub[0]}) begin
        fails++;
        $display("FAIL phase_model edge %0d: got %b expected %b", n,
                 {Clk_2Hz, LEFT}, {m_clk, m_pub[0]});
      end
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    SW_LEFT = 0; SW_RIGHT = 0; SW_HAZ = 0;
    do_reset();
    SW_LEFT = 1;
    SW_RIGHT = 1;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (LEFT === 1'b1 && RIGHT === 1'b1) done = 1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL both_on: got %b%b expected 11", LEFT, RIGHT);
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (Clk_2Hz === 1'b1) done = 1;
    end
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tests++;
    if ({Clk_2Hz, LEFT, RIGHT} !== 3'b000) begin
      fails++;
      $display("FAIL mid_reset: got %b expected 000", {Clk_2Hz, LEFT, RIGHT});
    end
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (LEFT === 1'b1 && RIGHT === 1'b1) done = 1;
    end
    tests++;
    if (!done || n != PER || Clk_2Hz !== 1'b0) begin
      fails++;
      $display("FAIL reset_recover: back at edge %0d clk=%b expected edge %0d clk=0",
               n, Clk_2Hz, PER);
    end
  endtask

  task automatic test_haz();
    bit seen;
    logic exp1;
    logic exp2;
    SW_LEFT = 0; SW_RIGHT = 0; SW_HAZ = 0;
    do_reset();
    seen = 0;
    for (int p = 0; p < 2; p++) begin
      SW_HAZ = 1;
      for (int i = 0; i < 40; i++) begin
        if (i == 10) SW_HAZ = 0;
        tick();
        if (HAZ === 1'b1) seen = 1;
        tests++;
        if (HAZ !== m_pub[2]) begin
          fails++;
          $display("FAIL haz_model press%0d cyc%0d: got %b expected %b", p, i, HAZ, m_pub[2]);
        end
      end
`ifdef HAZ_TOGGLE_EN
      exp1 = (p == 0);
`else
      exp1 = 1'b0;
`endif
      exp2 = 1'b1;
      tests++;
      if (HAZ !== exp1 || seen != exp2) begin
        fails++;
        $display("FAIL haz_press%0d: got haz=%b seen=%0d expected haz=%b seen=1",
                 p, HAZ, seen, exp1);
      end
    end
  endtask

  task automatic test_random();
    int hold [3];
    for (int i = 0; i < 3; i++) hold[i] = 0;
    SW_LEFT = 0; SW_RIGHT = 0; SW_HAZ = 0;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          hold[i] = int'($urandom_range(1, 14));
          case (i)
            0: SW_LEFT = ~SW_LEFT;
            1: SW_RIGHT = ~SW_RIGHT;
            default: SW_HAZ = ~SW_HAZ;
          endcase
        end
        hold[i]--;
      end
      Reset = ($urandom_range(0, 299) == 0);
      tick();
      Reset = 1'b0;
      tests++;
      if ({Clk_2Hz, LEFT, RIGHT, HAZ} !== {m_clk, m_pub[0], m_pub[1], m_pub[2]}) begin
        fails++;
        $display("FAIL random cyc%0d: got %b expected %b", c,
                 {Clk_2Hz, LEFT, RIGHT, HAZ}, {m_clk, m_pub[0], m_pub[1], m_pub[2]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_step();
    test_glitch();
    test_phase();
    test_reset_mid();
    test_haz();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
